// File: rtl/tournament_branch_predictor_if.sv
// Fetch/decode-side signal bundle for the tournament branch predictor.
// The pipeline drives it through the master modport; the predictor uses the slave modport.
interface tournament_branch_predictor_if;
  logic        STALL;
  logic [31:0] IF_PC;
  logic [31:0] ID_PC;
  logic [31:0] ID_Alt_PC;
  logic        ID_Is_Branch;
  logic        ID_Is_Taken;
  logic        ID_Is_Call;
  logic        ID_Is_Return;
  logic        flush;
  logic        take;
  logic [31:0] alt_address;

  modport master (
    output STALL, IF_PC, ID_PC, ID_Alt_PC,
    output ID_Is_Branch, ID_Is_Taken, ID_Is_Call, ID_Is_Return,
    input  flush, take, alt_address
  );

  modport slave (
    input  STALL, IF_PC, ID_PC, ID_Alt_PC,
    input  ID_Is_Branch, ID_Is_Taken, ID_Is_Call, ID_Is_Return,
    output flush, take, alt_address
  );
endinterface

// File: rtl/tournament_branch_predictor.sv
// Tournament direction predictor (gshare + per-PC local history + chooser) with a
// direct-mapped BTB and return stack; predicts in IF, verifies and repairs in ID.
module tournament_branch_predictor #(
  parameter int GHR_BITS   = 8,
  parameter int LHT_IDX    = 6,
  parameter int LHIST_BITS = 6,
  parameter int CH_IDX     = 8,
  parameter int BTB_IDX    = 5,
  parameter int RAS_DEPTH  = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  tournament_branch_predictor_if.slave  bp
);

  localparam int G_N   = 1 << GHR_BITS;
  localparam int L_N   = 1 << LHIST_BITS;
  localparam int LHT_N = 1 << LHT_IDX;
  localparam int CH_N  = 1 << CH_IDX;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = 30 - BTB_IDX;
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = RAS_W + 1;

  typedef enum logic [1:0] {BT_COND = 2'd0, BT_CALL = 2'd1, BT_RET = 2'd2} btb_type_e;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Tables and state
  logic [1:0]            gpht_q    [G_N];
  logic [1:0]            lpht_q    [L_N];
  logic [1:0]            chooser_q [CH_N];
  logic [LHIST_BITS-1:0] lht_q     [LHT_N];
  logic                  btb_valid_q  [BTB_N];
  logic [TAG_W-1:0]      btb_tag_q    [BTB_N];
  logic [31:0]           btb_target_q [BTB_N];
  btb_type_e             btb_type_q   [BTB_N];
  logic [31:0]           ras_q [RAS_DEPTH];

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [RAS_W-1:0]    ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;

  logic                rec_valid_q, rec_valid_d;
  logic                rec_take_q, rec_take_d;
  logic [31:0]         rec_target_q, rec_target_d;
  logic [GHR_BITS-1:0] rec_ghr_q, rec_ghr_d;
  logic                rec_gdir_q, rec_gdir_d;
  logic                rec_ldir_q, rec_ldir_d;

  // IF-side lookup
  logic [BTB_IDX-1:0]  if_btb_idx;
  logic                if_hit, if_gdir, if_ldir, if_choose_g;
  logic                pred_take;
  logic [31:0]         pred_target, ras_top;

  assign if_btb_idx  = bp.IF_PC[BTB_IDX+1:2];
  assign if_hit      = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == bp.IF_PC[31:BTB_IDX+2]);
  assign if_gdir     = gpht_q[ghr_q ^ bp.IF_PC[GHR_BITS+1:2]][1];
  assign if_ldir     = lpht_q[lht_q[bp.IF_PC[LHT_IDX+1:2]]][1];
  assign if_choose_g = chooser_q[bp.IF_PC[CH_IDX+1:2]][1];
  assign ras_top     = ras_q[ras_ptr_q - 1'b1];

  always_comb begin
    pred_take   = 1'b0;
    pred_target = btb_target_q[if_btb_idx];
    if (if_hit) begin
      case (btb_type_q[if_btb_idx])
        BT_COND: pred_take = if_choose_g ? if_gdir : if_ldir;
        BT_CALL: pred_take = 1'b1;
        BT_RET: begin
          pred_take   = (ras_cnt_q != '0);
          pred_target = ras_top;
        end
        default: pred_take = 1'b0;
      endcase
    end
  end

  // ID-side resolution
  logic        actual_taken, resolve_en, mispredict, upd_en, upd_br;
  logic [31:0] corr_addr;

  assign actual_taken = bp.ID_Is_Call | bp.ID_Is_Return | (bp.ID_Is_Branch & bp.ID_Is_Taken);
  assign resolve_en   = rec_valid_q &&
                        (bp.ID_Is_Branch || bp.ID_Is_Call || bp.ID_Is_Return);
  assign mispredict   = resolve_en && ((actual_taken != rec_take_q) ||
                                       (actual_taken && (rec_target_q != bp.ID_Alt_PC)));
  assign corr_addr    = actual_taken ? bp.ID_Alt_PC : bp.ID_PC + 32'd8;
  assign upd_en       = !bp.STALL && resolve_en;
  assign upd_br       = upd_en && bp.ID_Is_Branch;

  // A correction in ID always overrides whatever IF is predicting this cycle.
  always_comb begin
    bp.flush       = 1'b0;
    bp.take        = 1'b0;
    bp.alt_address = 32'd0;
    if (!bp.STALL) begin
      if (mispredict) begin
        bp.flush       = 1'b1;
        bp.alt_address = corr_addr;
      end else if (if_hit) begin
        bp.take        = pred_take;
        bp.alt_address = pred_target;
      end
    end
  end

  // Table write ports
  logic [GHR_BITS-1:0]   gpht_widx;
  logic [1:0]            gpht_d, lpht_d, chooser_d;
  logic [LHT_IDX-1:0]    lht_widx;
  logic [LHIST_BITS-1:0] lpht_widx, lht_d;
  logic [CH_IDX-1:0]     chooser_widx;
  logic                  chooser_we, btb_we;
  logic [BTB_IDX-1:0]    btb_widx;
  btb_type_e             btb_type_d;
  logic                  ras_we;

  always_comb begin
    gpht_widx    = rec_ghr_q ^ bp.ID_PC[GHR_BITS+1:2];
    gpht_d       = sat2(gpht_q[gpht_widx], bp.ID_Is_Taken);
    lht_widx     = bp.ID_PC[LHT_IDX+1:2];
    lpht_widx    = lht_q[lht_widx];
    lpht_d       = sat2(lpht_q[lpht_widx], bp.ID_Is_Taken);
    lht_d        = {lht_q[lht_widx][LHIST_BITS-2:0], bp.ID_Is_Taken};
    chooser_widx = bp.ID_PC[CH_IDX+1:2];
    // Chooser only learns when the components disagree; up means "trust global".
    chooser_we   = upd_br && (rec_gdir_q != rec_ldir_q);
    chooser_d    = sat2(chooser_q[chooser_widx], rec_gdir_q == bp.ID_Is_Taken);
    ghr_d        = upd_br ? {ghr_q[GHR_BITS-2:0], bp.ID_Is_Taken} : ghr_q;
    btb_we       = upd_en && actual_taken;
    btb_widx     = bp.ID_PC[BTB_IDX+1:2];
    btb_type_d   = bp.ID_Is_Return ? BT_RET : (bp.ID_Is_Call ? BT_CALL : BT_COND);
    ras_we       = 1'b0;
    ras_ptr_d    = ras_ptr_q;
    ras_cnt_d    = ras_cnt_q;
    if (upd_en && bp.ID_Is_Return) begin
      if (ras_cnt_q != '0) begin
        ras_ptr_d = ras_ptr_q - 1'b1;
        ras_cnt_d = ras_cnt_q - 1'b1;
      end
    end else if (upd_en && bp.ID_Is_Call) begin
      // A full stack wraps and silently overwrites its oldest entry.
      ras_we    = 1'b1;
      ras_ptr_d = ras_ptr_q + 1'b1;
      ras_cnt_d = (ras_cnt_q == CNT_W'(RAS_DEPTH)) ? ras_cnt_q : ras_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rec_valid_d  = rec_valid_q;
    rec_take_d   = rec_take_q;
    rec_target_d = rec_target_q;
    rec_ghr_d    = rec_ghr_q;
    rec_gdir_d   = rec_gdir_q;
    rec_ldir_d   = rec_ldir_q;
    if (!bp.STALL) begin
      rec_valid_d  = !mispredict;
      rec_take_d   = pred_take;
      rec_target_d = pred_target;
      rec_ghr_d    = ghr_q;
      rec_gdir_d   = if_gdir;
      rec_ldir_d   = if_ldir;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < G_N; i++)   gpht_q[i]    <= 2'b01;
      for (int i = 0; i < L_N; i++)   lpht_q[i]    <= 2'b01;
      for (int i = 0; i < CH_N; i++)  chooser_q[i] <= 2'b01;
      for (int i = 0; i < LHT_N; i++) lht_q[i]     <= '0;
    end else begin
      if (upd_br) begin
        gpht_q[gpht_widx] <= gpht_d;
        lpht_q[lpht_widx] <= lpht_d;
        lht_q[lht_widx]   <= lht_d;
      end
      if (chooser_we) chooser_q[chooser_widx] <= chooser_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_type_q[i]   <= BT_COND;
      end
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      if (btb_we) begin
        btb_valid_q[btb_widx]  <= 1'b1;
        btb_tag_q[btb_widx]    <= bp.ID_PC[31:BTB_IDX+2];
        btb_target_q[btb_widx] <= bp.ID_Alt_PC;
        btb_type_q[btb_widx]   <= btb_type_d;
      end
      if (ras_we) ras_q[ras_ptr_q] <= bp.ID_PC + 32'd8;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ghr_q        <= '0;
      ras_ptr_q    <= '0;
      ras_cnt_q    <= '0;
      rec_valid_q  <= 1'b0;
      rec_take_q   <= 1'b0;
      rec_target_q <= '0;
      rec_ghr_q    <= '0;
      rec_gdir_q   <= 1'b0;
      rec_ldir_q   <= 1'b0;
    end else begin
      ghr_q        <= ghr_d;
      ras_ptr_q    <= ras_ptr_d;
      ras_cnt_q    <= ras_cnt_d;
      rec_valid_q  <= rec_valid_d;
      rec_take_q   <= rec_take_d;
      rec_target_q <= rec_target_d;
      rec_ghr_q    <= rec_ghr_d;
      rec_gdir_q   <= rec_gdir_d;
      rec_ldir_q   <= rec_ldir_d;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^bp.IF_PC[1:0];

endmodule
